// File: rtl/rlbp_stream_rx_if.sv
// rtl/rlbp_stream_rx_if.sv - Wishbone classic slave bundle for rlbp_stream_rx
//
// Signals: wbs_cyc_i/wbs_stb_i/wbs_we_i cycle controls, wbs_sel_i byte
// selects, wbs_adr_i address, wbs_dat_i write data, wbs_ack_o acknowledge,
// wbs_dat_o read data. The slave modport is the register block side and
// the master modport is the bus initiator side.
interface rlbp_stream_rx_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/rlbp_stream_rx.sv
// rtl/rlbp_stream_rx.sv - serial pixel-macro word receiver with Wishbone FIFO readout
//
// Ports: wb_clk_i sole clock; wb_rst_i synchronous active-high reset;
// wbs Wishbone classic slave (DATA/STATUS/CTRL registers at BASE_ADDR);
// rlbp_clk_i/rlbp_data_i/rlbp_start_i/rlbp_done_i asynchronous serial
// inputs; irq_o registered level interrupt.
module rlbp_stream_rx #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          WORD_W     = 8,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    rlbp_stream_rx_if.slave        wbs,
    input  logic                   rlbp_clk_i,
    input  logic                   rlbp_data_i,
    input  logic                   rlbp_start_i,
    input  logic                   rlbp_done_i,
    output logic                   irq_o
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = FIFO_DEPTH[AW:0];
    localparam logic [5:0]  LAST_BIT = 6'(WORD_W - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Synchronizers, bit order {done, start, data, clk}
    logic [3:0] sync1, sync2, sync_d, rise;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1  <= '0;
            sync2  <= '0;
            sync_d <= '0;
        end else begin
            sync1  <= {rlbp_done_i, rlbp_start_i, rlbp_data_i, rlbp_clk_i};
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign rise = sync2 & ~sync_d;

    logic clk_rise, start_rise, done_rise, data_bit;
    assign clk_rise   = rise[0];
    assign data_bit   = sync2[1];
    assign start_rise = rise[2];
    assign done_rise  = rise[3];

    // Control / status registers
    logic enable, irq_en, clear_pend;
    logic sticky_ov, sticky_fd, sticky_frag;
    logic [0:0] state;
    logic [5:0] bit_cnt;
    logic [WORD_W-1:0] shreg, shift_next;

    // Wishbone decode; the ~ack term keeps acks from running back-to-back
    logic       addr_hit, wb_req, pop, wr_status, wr_ctrl;
    logic [1:0] reg_off;
    assign addr_hit  = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wb_req    = wbs.wbs_cyc_i & wbs.wbs_stb_i & addr_hit & ~wbs.wbs_ack_o;
    assign reg_off   = wbs.wbs_adr_i[3:2];
    assign wr_status = wb_req & wbs.wbs_we_i & (reg_off == 2'd1) & wbs.wbs_sel_i[1];
    assign wr_ctrl   = wb_req & wbs.wbs_we_i & (reg_off == 2'd2) & wbs.wbs_sel_i[0];

    // FIFO
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              fifo_full, fifo_empty;
    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign pop        = wb_req & ~wbs.wbs_we_i & (reg_off == 2'd0) & ~fifo_empty;

    // Receive path events; done has priority over restart, restart over data
    logic in_shift, push, do_push, set_ov, set_fd, set_frag;
    assign in_shift   = (state == SHIFT) & enable;
    assign shift_next = (shreg << 1) | WORD_W'(data_bit);
    assign push       = in_shift & ~done_rise & ~start_rise & clk_rise & (bit_cnt == LAST_BIT);
    assign do_push    = push & (~fifo_full | pop) & ~clear_pend;
    assign set_ov     = push & fifo_full & ~pop & ~clear_pend;
    assign set_fd     = in_shift & done_rise;
    assign set_frag   = in_shift & ((done_rise & (bit_cnt != '0)) | (~done_rise & start_rise));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rise && enable) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                default: begin
                    if (!enable || done_rise) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (start_rise) begin
                        bit_cnt <= '0;
                    end else if (clk_rise) begin
                        shreg   <= shift_next;
                        bit_cnt <= push ? 6'd0 : bit_cnt + 6'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem[wr_ptr] <= shift_next;
    end

    // fifo_clear takes effect one cycle after the CTRL write
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clear_pend) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, pop};
        end
    end

    // Read mux
    logic [31:0] status_word, rdata;
    assign status_word = {18'b0, state == SHIFT, sticky_frag, sticky_fd, sticky_ov,
                          fifo_full, fifo_empty, 1'b0, 7'(count)};

    always_comb begin
        rdata = 32'h0;
        case (reg_off)
            2'd0:    rdata = fifo_empty ? 32'h0 : (32'h8000_0000 | 32'(mem[rd_ptr]));
            2'd1:    rdata = status_word;
            2'd2:    rdata = {30'b0, irq_en, enable};
            default: rdata = 32'h0;
        endcase
    end

    // Sticky flags: a new event in the same cycle as a W1C wins
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            enable        <= 1'b0;
            irq_en        <= 1'b0;
            clear_pend    <= 1'b0;
            sticky_ov     <= 1'b0;
            sticky_fd     <= 1'b0;
            sticky_frag   <= 1'b0;
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= 32'h0;
            irq_o         <= 1'b0;
        end else begin
            wbs.wbs_ack_o <= wb_req;
            wbs.wbs_dat_o <= (wb_req && !wbs.wbs_we_i) ? rdata : 32'h0;
            clear_pend    <= wr_ctrl & wbs.wbs_dat_i[2];
            if (wr_ctrl) begin
                enable <= wbs.wbs_dat_i[0];
                irq_en <= wbs.wbs_dat_i[1];
            end
            sticky_ov   <= (sticky_ov   & ~(wr_status & wbs.wbs_dat_i[10])) | set_ov;
            sticky_fd   <= (sticky_fd   & ~(wr_status & wbs.wbs_dat_i[11])) | set_fd;
            sticky_frag <= (sticky_frag & ~(wr_status & wbs.wbs_dat_i[12])) | set_frag;
            irq_o       <= irq_en & (sticky_fd | sticky_ov);
        end
    end

    logic unused_ok;
    assign unused_ok = ^{wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3:2],
                         wbs.wbs_dat_i[31:13], wbs.wbs_dat_i[9:3]};
endmodule
